// File: rtl/spi_slave_ram.sv
// RAM stage behind the SPI slave: decodes 10-bit rx words into address/data
// writes and reads; optional protocol-error flag enabled by SPI_RAM_SEQ_ERR_EN.
module spi_slave_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter bit AUTO_INC  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid
`ifdef SPI_RAM_SEQ_ERR_EN
    ,
    output logic       seq_err
`endif
);

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    logic [1:0]           cmd_s;
    logic [7:0]           payload_s;
    logic [7:0]           mem_r [0:MEM_DEPTH-1];
    logic [ADDR_SIZE-1:0] wr_addr_r;
    logic [ADDR_SIZE-1:0] rd_addr_r;
    logic [ADDR_SIZE-1:0] wr_addr_nxt_s;
    logic [ADDR_SIZE-1:0] rd_addr_nxt_s;
    logic [7:0]           tx_data_nxt_s;
    logic                 tx_valid_nxt_s;
    logic                 mem_we_s;
    logic                 wr_in_range_s;
    logic                 rd_in_range_s;
    logic [7:0]           rd_word_s;

    // Non-power-of-2 depths leave a hole at the top of the address space.
    function automatic logic addr_in_range(input logic [ADDR_SIZE-1:0] addr);
        return ({{(32-ADDR_SIZE){1'b0}}, addr} < 32'(MEM_DEPTH));
    endfunction

    function automatic logic [ADDR_SIZE-1:0] addr_incr(input logic [ADDR_SIZE-1:0] addr);
        if (addr == ADDR_SIZE'(MEM_DEPTH - 1)) begin
            return {ADDR_SIZE{1'b0}};
        end else begin
            return addr + ADDR_SIZE'(1);
        end
    endfunction

    assign cmd_s         = rx_data[9:8];
    assign payload_s     = rx_data[7:0];
    assign wr_in_range_s = addr_in_range(wr_addr_r);
    assign rd_in_range_s = addr_in_range(rd_addr_r);
    assign rd_word_s     = rd_in_range_s ? mem_r[rd_addr_r] : 8'h00;

`ifdef SPI_RAM_SEQ_ERR_EN
    logic wr_loaded_r;
    logic rd_loaded_r;
    logic wr_loaded_nxt_s;
    logic rd_loaded_nxt_s;
    logic seq_err_nxt_s;

    // Loaded flags and error pulse; offending commands still execute.
    always_comb begin
        wr_loaded_nxt_s = wr_loaded_r;
        rd_loaded_nxt_s = rd_loaded_r;
        seq_err_nxt_s   = 1'b0;
        if (rx_valid) begin
            case (cmd_s)
                CMD_WR_ADDR: wr_loaded_nxt_s = 1'b1;
                CMD_WR_DATA: seq_err_nxt_s   = ~wr_loaded_r;
                CMD_RD_ADDR: rd_loaded_nxt_s = 1'b1;
                CMD_RD_DATA: seq_err_nxt_s   = ~rd_loaded_r;
                default:     seq_err_nxt_s   = 1'b0;
            endcase
        end else begin
            seq_err_nxt_s = 1'b0;
        end
    end

    // Sequence-check state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_loaded_r <= 1'b0;
            rd_loaded_r <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            wr_loaded_r <= wr_loaded_nxt_s;
            rd_loaded_r <= rd_loaded_nxt_s;
            seq_err     <= seq_err_nxt_s;
        end
    end
`endif

    // Command decode; everything holds when no rx word arrives.
    always_comb begin
        wr_addr_nxt_s  = wr_addr_r;
        rd_addr_nxt_s  = rd_addr_r;
        tx_data_nxt_s  = tx_data;
        tx_valid_nxt_s = tx_valid;
        mem_we_s       = 1'b0;
        if (rx_valid) begin
            case (cmd_s)
                CMD_WR_ADDR: begin
                    wr_addr_nxt_s  = payload_s[ADDR_SIZE-1:0];
                    tx_valid_nxt_s = 1'b0;
                end
                CMD_WR_DATA: begin
                    mem_we_s       = wr_in_range_s;
                    tx_valid_nxt_s = 1'b0;
                    if (AUTO_INC) begin
                        wr_addr_nxt_s = addr_incr(wr_addr_r);
                    end else begin
                        wr_addr_nxt_s = wr_addr_r;
                    end
                end
                CMD_RD_ADDR: begin
                    rd_addr_nxt_s  = payload_s[ADDR_SIZE-1:0];
                    tx_valid_nxt_s = 1'b0;
                end
                CMD_RD_DATA: begin
                    tx_data_nxt_s  = rd_word_s;
                    tx_valid_nxt_s = 1'b1;
                    if (AUTO_INC) begin
                        rd_addr_nxt_s = addr_incr(rd_addr_r);
                    end else begin
                        rd_addr_nxt_s = rd_addr_r;
                    end
                end
                default: begin
                    tx_valid_nxt_s = tx_valid;
                end
            endcase
        end else begin
            tx_valid_nxt_s = tx_valid;
        end
    end

    // Address and readback registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_r <= {ADDR_SIZE{1'b0}};
            rd_addr_r <= {ADDR_SIZE{1'b0}};
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
        end else begin
            wr_addr_r <= wr_addr_nxt_s;
            rd_addr_r <= rd_addr_nxt_s;
            tx_data   <= tx_data_nxt_s;
            tx_valid  <= tx_valid_nxt_s;
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[wr_addr_r] <= payload_s;
        end
    end

endmodule
